// File: rtl/instr_mem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory: load FSM states,
// the NOP word and the {opcode, dest, src1, src0} instruction encoding helpers.
package instr_mem_loadable_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE   = 2'd0,
    IMEM_LOAD   = 2'd1,
    IMEM_COMMIT = 2'd2
  } imem_state_t;

  localparam int          IMEM_WORD_WIDTH = 28;
  localparam logic [27:0] NOP_WORD        = 28'd0;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MOV = 4'd3;

  // 4-bit opcode followed by three 8-bit register/literal fields.
  function automatic logic [27:0] encode_instr(
    input logic [3:0] op,
    input logic [7:0] dest,
    input logic [7:0] src1,
    input logic [7:0] src0
  );
    return {op, dest, src1, src0};
  endfunction

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Fetch and program-load signals of the loadable instruction memory.
// The host/fetch side uses the master modport, the memory the slave modport.
interface instr_mem_loadable_if #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16
);

  logic                  iFetchEnable;
  logic [ADDR_WIDTH-1:0] iAddress;
  logic [DATA_WIDTH-1:0] oInstruction;
  logic                  oInstructionValid;
  logic                  iLoadStart;
  logic                  iLoadValid;
  logic [DATA_WIDTH-1:0] iLoadData;
  logic                  iLoadLast;
  logic                  oLoadReady;
  logic                  oLoadBusy;
  logic [ADDR_WIDTH:0]   oProgLength;
  logic                  oLoadOverflow;
  logic                  oParityError;

  modport master (
    output iFetchEnable, iAddress, iLoadStart, iLoadValid, iLoadData, iLoadLast,
    input  oInstruction, oInstructionValid, oLoadReady, oLoadBusy,
    input  oProgLength, oLoadOverflow, oParityError
  );

  modport slave (
    input  iFetchEnable, iAddress, iLoadStart, iLoadValid, iLoadData, iLoadLast,
    output oInstruction, oInstructionValid, oLoadReady, oLoadBusy,
    output oProgLength, oLoadOverflow, oParityError
  );

endinterface

// File: rtl/imem_ram_sp.sv
// Single-port storage array: synchronous write, registered read.
// A write takes priority over a read; the read register holds when idle.
module imem_ram_sp #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[addr] <= wdata;
    end else if (re) begin
      rdata_reg <= mem_reg[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory with a registered fetch port and a valid/ready
// program-load port. Optional per-word even parity when IMEM_PARITY_EN is defined.
module instr_mem_loadable
  import instr_mem_loadable_pkg::*;
#(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic               clk,
  input  logic               rst,
  instr_mem_loadable_if.slave bus
);

  localparam int                  RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int RAM_W = DATA_WIDTH + 1;
`else
  localparam int RAM_W = DATA_WIDTH;
`endif

  imem_state_t         state_reg, state_next;
  logic [ADDR_WIDTH:0] ptr_reg;
  logic [ADDR_WIDTH:0] prog_len_reg;
  logic                overflow_reg;
  logic                out_sel_reg;
  logic                valid_reg;

  logic                load_fire;
  logic                ptr_has_room;
  logic                fetch_in_range;
  logic                ram_we;
  logic                ram_re;
  logic [RAM_AW-1:0]   ram_addr;
  logic [RAM_W-1:0]    wr_word;
  logic [RAM_W-1:0]    rd_word;

  assign load_fire      = (state_reg == IMEM_LOAD) && bus.iLoadValid;
  assign ptr_has_room   = ptr_reg < DEPTH_W;
  assign fetch_in_range = {1'b0, bus.iAddress} < prog_len_reg;
  assign ram_we         = load_fire && ptr_has_room;
  // Reads only happen in IDLE, so the port never sees a read during a write.
  assign ram_re         = (state_reg == IMEM_IDLE) && bus.iFetchEnable && fetch_in_range;
  assign ram_addr       = ram_we ? ptr_reg[RAM_AW-1:0] : bus.iAddress[RAM_AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IMEM_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bus.oLoadReady = 1'b0;
    bus.oLoadBusy  = 1'b0;
    case (state_reg)
      IMEM_IDLE: begin
        if (bus.iLoadStart) begin
          state_next = IMEM_LOAD;
        end
      end
      IMEM_LOAD: begin
        bus.oLoadReady = 1'b1;
        bus.oLoadBusy  = 1'b1;
        if (bus.iLoadValid && bus.iLoadLast) begin
          state_next = IMEM_COMMIT;
        end
      end
      IMEM_COMMIT: begin
        bus.oLoadBusy = 1'b1;
        state_next    = IMEM_IDLE;
      end
      default: begin
        state_next = IMEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg      <= '0;
      prog_len_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IMEM_IDLE: begin
          if (bus.iLoadStart) begin
            ptr_reg      <= '0;
            overflow_reg <= 1'b0;
          end
        end
        IMEM_LOAD: begin
          if (load_fire) begin
            if (ptr_has_room) begin
              ptr_reg <= ptr_reg + 1'b1;
            end else begin
              overflow_reg <= 1'b1;
            end
          end
        end
        IMEM_COMMIT: begin
          // The pointer saturates at DEPTH, so it already equals min(count, DEPTH).
          prog_len_reg <= ptr_reg;
        end
        default: begin
          ptr_reg <= ptr_reg;
        end
      endcase
    end
  end

  // out_sel_reg marks whether the RAM read register holds the word being shown;
  // when clear the output is forced to NOP without touching the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sel_reg <= 1'b0;
      valid_reg   <= 1'b0;
    end else if (state_reg == IMEM_IDLE) begin
      valid_reg <= bus.iFetchEnable;
      if (bus.iFetchEnable) begin
        out_sel_reg <= fetch_in_range;
      end
    end else begin
      valid_reg <= 1'b0;
      if (bus.iFetchEnable) begin
        out_sel_reg <= 1'b0;
      end
    end
  end

  imem_ram_sp #(
    .WIDTH (RAM_W),
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wr_word),
    .rdata (rd_word)
  );

`ifdef IMEM_PARITY_EN
  assign wr_word          = {^bus.iLoadData, bus.iLoadData};
  assign bus.oParityError = out_sel_reg && ((^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH]);
`else
  assign wr_word          = bus.iLoadData;
  assign bus.oParityError = 1'b0;
`endif

  assign bus.oInstruction      = out_sel_reg ? rd_word[DATA_WIDTH-1:0] : DATA_WIDTH'(NOP_WORD);
  assign bus.oInstructionValid = valid_reg;
  assign bus.oProgLength       = prog_len_reg;
  assign bus.oLoadOverflow     = overflow_reg;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Randomised bench for instr_mem_loadable against an array-based program model.
// Small DEPTH so overflow and out-of-range fetches are reached quickly.
module tb_instr_mem_loadable;
  import instr_mem_loadable_pkg::*;

  localparam int DW  = 28;
  localparam int AW  = 5;
  localparam int DEP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_mem_loadable_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instr_mem_loadable #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [DEP];
  int            model_len   = 0;
  logic [DW-1:0] model_instr = '0;
  bit            model_ovf   = 1'b0;
  bit            model_par   = 1'b0;
  int            flip_addr   = -1;
  logic [DW-1:0] prog_q [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int addr, input bit en);
    bus.iFetchEnable = en;
    bus.iAddress     = AW'(addr);
    tick();
    bus.iFetchEnable = 1'b0;
    if (en) begin
      model_instr = (addr < model_len) ? model_mem[addr] : '0;
      model_par   = (addr < model_len) && (addr == flip_addr);
    end
    check_eq("fetch_instr", 64'(bus.oInstruction), 64'(model_instr));
    check_eq("fetch_valid", 64'(bus.oInstructionValid), 64'(en));
    check_eq("fetch_parity", 64'(bus.oParityError), 64'(model_par));
    $display("fetch en=%0d addr=%0d instr=%h valid=%0d", en, addr, bus.oInstruction,
             bus.oInstructionValid);
  endtask

  // Loads prog_q; a 3-cycle valid gap (with one blocked fetch) is inserted before word gap_at.
  task automatic do_load(input int gap_at);
    int n;
    n = prog_q.size();
    bus.iLoadStart = 1'b1;
    tick();
    bus.iLoadStart = 1'b0;
    model_ovf = 1'b0;
    check_eq("start_ready", 64'(bus.oLoadReady), 64'd1);
    check_eq("start_busy", 64'(bus.oLoadBusy), 64'd1);
    check_eq("start_ovf_clear", 64'(bus.oLoadOverflow), 64'd0);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        bus.iLoadValid   = 1'b0;
        bus.iFetchEnable = 1'b1;
        bus.iAddress     = AW'($urandom_range(0, 2**AW - 1));
        tick();
        bus.iFetchEnable = 1'b0;
        model_instr = '0;
        model_par   = 1'b0;
        check_eq("load_fetch_instr", 64'(bus.oInstruction), 64'd0);
        check_eq("load_fetch_valid", 64'(bus.oInstructionValid), 64'd0);
        tick();
        tick();
        check_eq("gap_ready", 64'(bus.oLoadReady), 64'd1);
      end
      bus.iLoadValid = 1'b1;
      bus.iLoadData  = prog_q[i];
      bus.iLoadLast  = (i == n - 1);
      bus.iLoadStart = 1'($urandom_range(0, 1));
      tick();
      if (i < DEP) model_mem[i] = prog_q[i];
      else model_ovf = 1'b1;
    end
    bus.iLoadValid = 1'b0;
    bus.iLoadLast  = 1'b0;
    bus.iLoadStart = 1'b0;
    check_eq("commit_busy", 64'(bus.oLoadBusy), 64'd1);
    check_eq("commit_ready", 64'(bus.oLoadReady), 64'd0);
    tick();
    model_len = (n < DEP) ? n : DEP;
    check_eq("done_busy", 64'(bus.oLoadBusy), 64'd0);
    check_eq("prog_length", 64'(bus.oProgLength), 64'(model_len));
    check_eq("overflow", 64'(bus.oLoadOverflow), 64'(model_ovf));
    check_eq("load_hold_instr", 64'(bus.oInstruction), 64'(model_instr));
    $display("load words=%0d len=%0d ovf=%0d", n, bus.oProgLength, bus.oLoadOverflow);
  endtask

  task automatic fill_prog(input int n);
    prog_q.delete();
    for (int i = 0; i < n; i++) prog_q.push_back(DW'($urandom));
  endtask

  initial begin
    bus.iFetchEnable = 1'b0;
    bus.iAddress     = '0;
    bus.iLoadStart   = 1'b0;
    bus.iLoadValid   = 1'b0;
    bus.iLoadData    = '0;
    bus.iLoadLast    = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_instr", 64'(bus.oInstruction), 64'd0);
    check_eq("rst_valid", 64'(bus.oInstructionValid), 64'd0);
    check_eq("rst_ready", 64'(bus.oLoadReady), 64'd0);
    check_eq("rst_busy", 64'(bus.oLoadBusy), 64'd0);
    check_eq("rst_len", 64'(bus.oProgLength), 64'd0);
    check_eq("rst_ovf", 64'(bus.oLoadOverflow), 64'd0);
    check_eq("rst_parity", 64'(bus.oParityError), 64'd0);
    $display("reset released");

    do_fetch(0, 1'b1);
    check_eq("empty_len", 64'(bus.oProgLength), 64'd0);

    fill_prog(15);
    prog_q[6] = encode_instr(OP_ADD, 8'd5, 8'd4, 8'd3);
    do_load(7);
    do_fetch(6, 1'b1);
    check_eq("add_word", 64'(bus.oInstruction), 64'(encode_instr(OP_ADD, 8'd5, 8'd4, 8'd3)));
    do_fetch(15, 1'b1);
    do_fetch(14, 1'b1);
    do_fetch(3, 1'b0);
    for (int k = 0; k < 20; k++) do_fetch($urandom_range(0, 2**AW - 1), 1'($urandom_range(0, 3) != 0));

    fill_prog(DEP + 4);
    do_load(-1);
    do_fetch(DEP - 1, 1'b1);
    do_fetch(DEP, 1'b1);
    do_fetch(0, 1'b1);

    fill_prog(3);
    do_load(1);
    do_fetch(2, 1'b1);
    do_fetch(3, 1'b1);

    fill_prog(1);
    do_load(-1);
    do_fetch(0, 1'b1);
    do_fetch(1, 1'b1);

    fill_prog(10);
    bus.iLoadStart = 1'b1;
    tick();
    bus.iLoadStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.iLoadValid = 1'b1;
      bus.iLoadData  = prog_q[i];
      tick();
    end
    bus.iLoadValid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_len = 0; model_instr = '0; model_ovf = 1'b0; model_par = 1'b0;
    check_eq("midrst_ready", 64'(bus.oLoadReady), 64'd0);
    check_eq("midrst_busy", 64'(bus.oLoadBusy), 64'd0);
    check_eq("midrst_len", 64'(bus.oProgLength), 64'd0);
    check_eq("midrst_instr", 64'(bus.oInstruction), 64'd0);
    $display("reset during load");
    for (int a = 0; a < 4; a++) do_fetch(a, 1'b1);

    for (int r = 0; r < 4; r++) begin
      fill_prog($urandom_range(1, DEP + 4));
      do_load($urandom_range(0, 1) != 0 ? $urandom_range(0, prog_q.size() - 1) : -1);
      for (int k = 0; k < 10; k++) do_fetch($urandom_range(0, 2**AW - 1), 1'($urandom_range(0, 3) != 0));
    end

`ifdef IMEM_PARITY_EN
    fill_prog(8);
    do_load(-1);
    dut.u_ram.mem_reg[3][DW] = ~dut.u_ram.mem_reg[3][DW];
    flip_addr = 3;
    do_fetch(3, 1'b1);
    do_fetch(2, 1'b1);
    flip_addr = -1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
